// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU executing {inverse, funct3} operations with
// valid/ready handshakes on both sides and at most one op in flight.
// Optional build macro ALU_BARREL_SHIFT_EN: shifts complete in one cycle at
// accept; otherwise shifts iterate one bit per cycle (default).
module alu_exec_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int unsigned SHAMT_W = $clog2(XLEN);

`ifdef ALU_BARREL_SHIFT_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DONE = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;
`endif

   // All non-shift operations; shift codes are resolved separately
   function automatic logic [XLEN-1:0] alu_basic(input logic [3:0]      ctl,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic            lt_s;
      logic            lt_u;
      logic [XLEN-1:0] r;
      lt_s = $signed(a) < $signed(b);
      lt_u = a < b;
      r    = '0;
      case (ctl)
         4'b0000: r = a + b;
         4'b1000: r = a - b;
         4'b0010: r = {{(XLEN-1){1'b0}}, lt_s};
         4'b1010: r = {{(XLEN-1){1'b0}}, ~lt_s};
         4'b0011: r = {{(XLEN-1){1'b0}}, lt_u};
         4'b1011: r = {{(XLEN-1){1'b0}}, ~lt_u};
         4'b0100: r = a ^ b;
         4'b1100: r = ~(a ^ b);
         4'b0110: r = a | b;
         4'b1110: r = ~(a | b);
         4'b0111: r = a & b;
         4'b1111: r = ~(a & b);
         default: r = '0;
      endcase
      return r;
   endfunction

   state_e            state_q, state_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              zero_q, zero_d;
   logic              accept;
   logic              is_shift;
   logic              shift_left;
   logic              shift_arith;
   logic [SHAMT_W-1:0] shamt;

`ifndef ALU_BARREL_SHIFT_EN
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               arith_q, arith_d;
   logic [XLEN-1:0]    step;
`endif

   // Handshake and decode of the presented operation
   always_comb begin
      in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
      accept      = in_valid && in_ready;
      is_shift    = (alu_control[1:0] == 2'b01);
      shift_left  = ~alu_control[2];
      shift_arith = alu_control[3] & alu_control[2];
      shamt       = op_b[SHAMT_W-1:0];
   end

   // Next-state, result and zero update
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
`ifndef ALU_BARREL_SHIFT_EN
      cnt_d    = cnt_q;
      left_d   = left_q;
      arith_d  = arith_q;
      step     = left_q ? {result_q[XLEN-2:0], 1'b0}
                        : {arith_q & result_q[XLEN-1], result_q[XLEN-1:1]};
`endif
      if (accept) begin
         state_d = ST_DONE;
`ifdef ALU_BARREL_SHIFT_EN
         if (is_shift) begin
            if (shift_left)
               result_d = op_a << shamt;
            else if (shift_arith)
               result_d = XLEN'($signed(op_a) >>> shamt);
            else
               result_d = op_a >> shamt;
         end else begin
            result_d = alu_basic(alu_control, op_a, op_b);
         end
`else
         if (is_shift) begin
            result_d = op_a;
            cnt_d    = shamt;
            left_d   = shift_left;
            arith_d  = shift_arith;
            if (shamt != '0)
               state_d = ST_SHIFT;
         end else begin
            result_d = alu_basic(alu_control, op_a, op_b);
         end
`endif
         zero_d = (result_d == '0);
`ifndef ALU_BARREL_SHIFT_EN
      end else if (state_q == ST_SHIFT) begin
         result_d = step;
         zero_d   = (step == '0);
         cnt_d    = cnt_q - SHAMT_W'(1);
         if (cnt_q == SHAMT_W'(1))
            state_d = ST_DONE;
`endif
      end else if ((state_q == ST_DONE) && out_ready) begin
         state_d = ST_IDLE;
      end
   end

   // State and datapath registers; reset discards any in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
         cnt_q    <= '0;
         left_q   <= 1'b0;
         arith_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
`ifndef ALU_BARREL_SHIFT_EN
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         arith_q  <= arith_d;
`endif
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; honours ALU_BARREL_SHIFT_EN.
module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   int total;
   int bad;

   alu_exec_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int shift_lat(input int sh);
`ifdef ALU_BARREL_SHIFT_EN
      return 1;
`else
      return (sh == 0) ? 1 : sh + 1;
`endif
   endfunction

   // Issue one op with out_ready=1, wait for the result and check it
   task automatic do_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input logic exp_z, input int exp_lat);
      int lat;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid    = 1'b1;
      alu_control = ctl;
      op_a        = a;
      op_b        = b;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      op_a        = 32'hDEAD_BEEF;
      op_b        = 32'h0000_0013;
      alu_control = 4'b0000;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (exp_lat > 1 && lat == 1)
            chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
         if (out_valid)
            break;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".res"}, result, exp_r);
      chk({tag, ".zero"}, 32'(zero), 32'(exp_z));
      @(posedge clk);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      alu_control = 4'b0000;
      op_a        = '0;
      op_b        = '0;
      out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.result", result, 32'd0);
      chk("rst.zero", 32'(zero), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);

      do_op("sub_eq",   4'b1000, 32'h5, 32'h5, 32'h0, 1'b1, 1);
      do_op("sub_wrap", 4'b1000, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1);
      do_op("add",      4'b0000, 32'h7, 32'h9, 32'h10, 1'b0, 1);
      do_op("sra4",     4'b1101, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, shift_lat(4));
      do_op("sra0",     4'b1101, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0, shift_lat(0));
      do_op("sll31",    4'b1001, 32'h1, 32'h1F, 32'h8000_0000, 1'b0, shift_lat(31));
      do_op("srl31",    4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 1'b0, shift_lat(31));
      do_op("sll_out",  4'b0001, 32'h0000_0003, 32'h1F, 32'h8000_0000, 1'b0, shift_lat(31));
      do_op("srl_zero", 4'b0101, 32'h0000_0001, 32'h2, 32'h0, 1'b1, shift_lat(2));
      do_op("xnor",     4'b1100, 32'h1234, 32'h1235, 32'hFFFF_FFFE, 1'b0, 1);
      do_op("bge",      4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1);
      do_op("bgeu",     4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
      do_op("slt",      4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
      do_op("sltu",     4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1);
      do_op("xor",      4'b0100, 32'hA5A5, 32'hFFFF, 32'h5A5A, 1'b0, 1);
      do_op("or",       4'b0110, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1);
      do_op("nor",      4'b1110, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
      do_op("nand",     4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);

      // Backpressure: result must hold while out_ready is low
      @(negedge clk);
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      alu_control = 4'b0111;
      op_a        = 32'hF0F0;
      op_b        = 32'hFF00;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a     = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp.valid", 32'(out_valid), 32'd1);
         chk("bp.res", result, 32'h0000_F000);
         chk("bp.in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp.drained", 32'(out_valid), 32'd0);

      // Streaming: eight back-to-back ADDs with out_ready held high
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("st.in_ready", 32'(in_ready), 32'd1);
         if (i > 0) begin
            chk("st.valid", 32'(out_valid), 32'd1);
            chk("st.res", result, 32'(i - 1 + 100));
         end
         in_valid    = 1'b1;
         alu_control = 4'b0000;
         op_a        = 32'(i);
         op_b        = 32'd100;
      end
      @(negedge clk);
      chk("st.valid_last", 32'(out_valid), 32'd1);
      chk("st.res_last", result, 32'd107);
      in_valid = 1'b0;
      @(negedge clk);
      chk("st.idle", 32'(out_valid), 32'd0);

      // Reset asserted in the middle of a long shift
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = 4'b0001;
      op_a        = 32'h1;
      op_b        = 32'd20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst.valid", 32'(out_valid), 32'd0);
      chk("mrst.res", result, 32'd0);
      chk("mrst.zero", 32'(zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst.in_ready", 32'(in_ready), 32'd1);
      chk("mrst.valid_after", 32'(out_valid), 32'd0);
      chk("mrst.res_after", result, 32'd0);
      repeat (25) @(negedge clk);
      chk("mrst.no_late", 32'(out_valid), 32'd0);
      do_op("post_rst", 4'b0000, 32'h1, 32'h2, 32'h3, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
